// File: rtl/counter_tick_ctrl.sv
// counter_tick_ctrl: clock-enable generator for the DE1_SoC 4-bit counter.
// While running, emits a one-cycle tick every P = DIV_BASE << div_sel cycles.
// While paused, emits one tick per debounced press of the step key.
module counter_tick_ctrl #(
    parameter int unsigned DIV_BASE  = 2097152,
    parameter int unsigned DIV_W     = 26,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned DB_W      = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_sw,
    input  logic [1:0] div_sel,
    input  logic       step_key_n,
    output logic       tick,
    output logic       running,
    output logic       key_db
);

    typedef enum logic [0:0] {
        StPaused,
        StRunning
    } state_e;

    localparam logic [DIV_W-1:0] DivBase = DIV_W'(DIV_BASE);
    localparam logic [DB_W-1:0]  DbLast  = DB_W'(DB_CYCLES - 1);

    // Synchronizer stages
    logic       run_s1_q;
    logic       run_s2_q;
    logic [1:0] div_s1_q;
    logic [1:0] div_s2_q;
    logic       key_s1_q;
    logic       key_s2_q;

    // Debouncer
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            key_db_q;
    logic            key_db_d;
    logic            key_db_prev_q;
    logic            press;

    // Rate divider and control FSM
    state_e           state_q;
    state_e           state_d;
    logic [DIV_W-1:0] dcnt_q;
    logic [DIV_W-1:0] dcnt_d;
    logic [DIV_W-1:0] period_m1;
    logic             tick_q;
    logic             tick_d;
    logic             running_q;

    // Two-flop synchronizers; the key idles high so its stages reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            div_s1_q <= 2'b00;
            div_s2_q <= 2'b00;
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            run_s1_q <= run_sw;
            run_s2_q <= run_s1_q;
            div_s1_q <= div_sel;
            div_s2_q <= div_s1_q;
            key_s1_q <= step_key_n;
            key_s2_q <= key_s1_q;
        end
    end

    // Debounce: count cycles of disagreement; adopt the new level once it has
    // persisted for DB_CYCLES cycles, and restart the count on any agreement.
    always_comb begin
        db_cnt_d = '0;
        key_db_d = key_db_q;
        if (key_s2_q != key_db_q) begin
            if (db_cnt_q == DbLast) begin
                key_db_d = key_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Debounce state, plus a one-cycle-delayed copy for fall detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q      <= '0;
            key_db_q      <= 1'b1;
            key_db_prev_q <= 1'b1;
        end else begin
            db_cnt_q      <= db_cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
        end
    end

    // Press event: debounced level has just fallen; the tick follows one edge later.
    assign press = key_db_prev_q & ~key_db_q;

    // Period minus one for the synced rate select; DIV_W is sized to hold it.
    assign period_m1 = (DivBase << div_s2_q) - DIV_W'(1);

    // FSM next-state, divider and tick request.
    // The >= compare lets a shrinking period fire at once instead of wrapping.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        tick_d  = 1'b0;
        case (state_q)
            StPaused: begin
                dcnt_d = '0;
                if (run_s2_q) begin
                    // A press coinciding with the start of a run is dropped.
                    state_d = StRunning;
                end else if (press) begin
                    tick_d = 1'b1;
                end
            end
            StRunning: begin
                if (!run_s2_q) begin
                    state_d = StPaused;
                    dcnt_d  = '0;
                end else if (dcnt_q >= period_m1) begin
                    tick_d = 1'b1;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = StPaused;
                dcnt_d  = '0;
            end
        endcase
    end

    // FSM state, divider and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StPaused;
            dcnt_q    <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            tick_q    <= tick_d;
            running_q <= (state_d == StRunning);
        end
    end

    assign tick    = tick_q;
    assign running = running_q;
    assign key_db  = key_db_q;

endmodule

// File: tb/tb_counter_tick_ctrl.sv
// Testbench for counter_tick_ctrl with DIV_BASE=4, DB_CYCLES=3.
// Expected tick edges are computed arithmetically from the edge at which
// stimulus was applied and compared with a log of observed tick edges.
module tb_counter_tick_ctrl;

    localparam int DivBase  = 4;
    localparam int DbCycles = 3;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       run_sw     = 1'b0;
    logic [1:0] div_sel    = 2'b00;
    logic       step_key_n = 1'b1;
    logic       tick;
    logic       running;
    logic       key_db;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   tick_log[$];
    logic tick_prev = 1'b0;

    counter_tick_ctrl #(
        .DIV_BASE (DivBase),
        .DIV_W    (8),
        .DB_CYCLES(DbCycles),
        .DB_W     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .div_sel   (div_sel),
        .step_key_n(step_key_n),
        .tick      (tick),
        .running   (running),
        .key_db    (key_db)
    );

    always #5 clk = ~clk;

    // Edge index: value k means the k-th rising edge has just occurred.
    always @(posedge clk) cyc <= cyc + 1;

    // Log the edge after which tick was high; ticks must never be adjacent.
    always @(negedge clk) begin
        if (tick) begin
            tick_log.push_back(cyc);
            n_checks++;
            if (tick_prev) begin
                n_fail++;
                $display("FAIL tick_single_cycle: tick high after edges %0d and %0d, required gap",
                         cyc - 1, cyc);
            end
        end
        tick_prev = tick;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_reset();
        rst        = 1'b0;
        run_sw     = 1'b0;
        div_sel    = 2'b00;
        step_key_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            run_sw     = 1'($urandom);
            div_sel    = 2'($urandom);
            step_key_n = 1'($urandom);
            step(1);
            n_checks++;
            if ({tick, running, key_db} !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: tick/running/key_db=%b, required 001",
                         i, {tick, running, key_db});
            end
        end
        idle_reset();
        div_sel = 2'd0;
        run_sw  = 1'b1;
        step(3 + 2 * DivBase);
        n_checks++;
        if ({tick, running} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_precondition: tick/running=%b, required 11", {tick, running});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({tick, running} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_async: tick/running=%b, required 00", {tick, running});
        end
        idle_reset();
    endtask

    task automatic test_run_rates(input logic [1:0] sel, input int n_ticks);
        int c0;
        int p;
        int exp_q[$];
        idle_reset();
        p       = DivBase << sel;
        div_sel = sel;
        run_sw  = 1'b1;
        c0      = cyc;
        tick_log.delete();
        step(2);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL run_rates_running_early sel=%0d: running=%b, required 0", sel, running);
        end
        step(1);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL run_rates_running sel=%0d: running=%b, required 1", sel, running);
        end
        step(p * n_ticks + 2);
        for (int k = 1; k <= n_ticks; k++) exp_q.push_back(c0 + 3 + p * k);
        n_checks++;
        if (tick_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL run_rates_count sel=%0d: got %0d ticks, required %0d",
                     sel, tick_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (tick_log[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL run_rates_edge sel=%0d #%0d: got edge %0d, required %0d",
                             sel, i, tick_log[i] - c0, exp_q[i] - c0);
                end
            end
        end
        run_sw = 1'b0;
        step(4);
    endtask

    // Shrink div_sel 3->0 so that the synced change meets dcnt == d.
    task automatic test_shrink(input int d);
        int c1;
        int exp_q[$];
        idle_reset();
        div_sel = 2'd3;
        run_sw  = 1'b1;
        tick_log.delete();
        step(1 + d);
        c1      = cyc;
        div_sel = 2'd0;
        step(16);
        for (int k = 0; k < 4; k++) exp_q.push_back(c1 + 3 + 4 * k);
        n_checks++;
        if (tick_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL shrink_count d=%0d: got %0d ticks, required %0d",
                     d, tick_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (tick_log[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL shrink_edge d=%0d #%0d: got edge %0d, required %0d",
                             d, i, tick_log[i] - c1, exp_q[i] - c1);
                end
            end
        end
        run_sw = 1'b0;
        step(4);
    endtask

    task automatic test_single_step(input int hold);
        int c0;
        idle_reset();
        tick_log.delete();
        c0         = cyc;
        step_key_n = 1'b0;
        step(DbCycles + 1);
        n_checks++;
        if (key_db !== 1'b1) begin
            n_fail++;
            $display("FAIL step_key_db_early: key_db=%b, required 1", key_db);
        end
        step(1);
        n_checks++;
        if (key_db !== 1'b0) begin
            n_fail++;
            $display("FAIL step_key_db_fall: key_db=%b, required 0", key_db);
        end
        step(hold - DbCycles - 2);
        step_key_n = 1'b1;
        step(12);
        n_checks++;
        if (key_db !== 1'b1) begin
            n_fail++;
            $display("FAIL step_key_db_release: key_db=%b, required 1", key_db);
        end
        n_checks++;
        if (tick_log.size() != 1) begin
            n_fail++;
            $display("FAIL step_count hold=%0d: got %0d ticks, required 1", hold, tick_log.size());
        end else begin
            n_checks++;
            if (tick_log[0] != c0 + DbCycles + 3) begin
                n_fail++;
                $display("FAIL step_edge hold=%0d: got edge %0d, required %0d",
                         hold, tick_log[0] - c0, DbCycles + 3);
            end
        end
    endtask

    task automatic test_bounce(input logic run);
        int c0;
        int seg[$];
        int exp_q[$];
        idle_reset();
        div_sel = 2'd0;
        run_sw  = run;
        c0      = cyc;
        tick_log.delete();
        step(6);
        // Alternating low/high run lengths, starting low; lows never reach 3 cycles.
        seg = '{2, 1, 2, 3};
        repeat (6) seg.push_back($urandom_range(1, 2));
        foreach (seg[i]) begin
            step_key_n = (i % 2 == 1);
            repeat (seg[i]) begin
                step(1);
                n_checks++;
                if (key_db !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce_key_db run=%b seg %0d: key_db=%b, required 1",
                             run, i, key_db);
                end
            end
        end
        step_key_n = 1'b1;
        step(6);
        if (run) begin
            for (int t = c0 + 3 + DivBase; t <= cyc - 1; t += DivBase) exp_q.push_back(t);
        end
        n_checks++;
        if (tick_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bounce_count run=%b: got %0d ticks, required %0d",
                     run, tick_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (tick_log[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bounce_edge run=%b #%0d: got edge %0d, required %0d",
                             run, i, tick_log[i] - c0, exp_q[i] - c0);
                end
            end
        end
        run_sw = 1'b0;
        step(4);
    endtask

    task automatic test_pause_resume();
        logic [1:0] sel;
        int         p;
        int         c1;
        int         late;
        idle_reset();
        sel     = 2'($urandom_range(0, 1));
        p       = DivBase << sel;
        div_sel = sel;
        run_sw  = 1'b1;
        tick_log.delete();
        step(3 + 3 * p);
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_third_tick: tick=%b, required 1", tick);
        end
        // Drop run_sw right on the third tick edge.
        run_sw = 1'b0;
        c1     = cyc;
        step(2);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_running_early: running=%b, required 1", running);
        end
        step(1);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_running_fall: running=%b, required 0", running);
        end
        step(100);
        late = 0;
        foreach (tick_log[i]) if (tick_log[i] > c1) late++;
        n_checks++;
        if (late != 0 || tick_log.size() != 3) begin
            n_fail++;
            $display("FAIL pause_quiet: got %0d ticks (%0d after pause), required 3 (0)",
                     tick_log.size(), late);
        end
        run_sw = 1'b1;
        step(3);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_running: running=%b, required 1", running);
        end
        step(p - 1);
        n_checks++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_tick_early: tick=%b, required 0", tick);
        end
        step(1);
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_first_tick: tick=%b, required 1", tick);
        end
        run_sw = 1'b0;
        step(4);
    endtask

    // Random presses and glitches while paused: a low of >= DB_CYCLES cycles
    // yields one tick DB_CYCLES+3 edges after it starts; shorter lows yield none.
    task automatic test_random_steps();
        int c0;
        int len;
        int exp_q[$];
        idle_reset();
        tick_log.delete();
        for (int n = 0; n < 10; n++) begin
            len        = $urandom_range(1, 8);
            c0         = cyc;
            step_key_n = 1'b0;
            if (len >= DbCycles) exp_q.push_back(c0 + DbCycles + 3);
            step(len);
            step_key_n = 1'b1;
            step($urandom_range(6, 10));
        end
        step(8);
        n_checks++;
        if (tick_log.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_steps_count: got %0d ticks, required %0d",
                     tick_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (tick_log[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_steps_edge #%0d: got edge %0d, required %0d",
                             i, tick_log[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_rates(2'd0, 4);
        test_run_rates(2'd3, 3);
        test_run_rates(2'($urandom_range(1, 2)), 3);
        test_shrink(20);
        test_shrink($urandom_range(3, 30));
        test_single_step(10);
        test_single_step($urandom_range(11, 14));
        test_bounce(1'b0);
        test_bounce(1'b1);
        test_pause_resume();
        test_random_steps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
